fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch stage that issues word fetches, buffers in-order responses and feeds the IF/ID register.
// Latency: a response arriving at an empty buffer reaches instruction_out one cycle later; buffered words follow back-to-back.
// Backpressure: at most two fetch credits (in flight plus buffered); id_stall freezes IF/ID while responses keep landing in the buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        id_flush
);

    // One buffered instruction word together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] dat;
        logic [31:0] pc;
    } ent_t;

    logic [31:0] pc_q, pc_d;
    logic [1:0]  out_q, out_d;
    logic [1:0]  drop_q, drop_d;
    logic [1:0]  cnt_q, cnt_d;
    ent_t        buf0_q, buf0_d;
    ent_t        buf1_q, buf1_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    logic [31:0] ifid_dat_q, ifid_dat_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic        ifid_flush_q, ifid_flush_d;

    logic        credit_ok;
    logic        req_fire;
    logic        rsp_drop;
    logic        rsp_keep;
    logic        pop;
    logic        push;
    logic [1:0]  cnt_pop;
    ent_t        rsp_ent;
    logic [31:0] redir_pc_al;

    // Credits cover both in-flight requests and words parked in the buffer, so
    // every response always has a slot and nothing can be lost.
    assign credit_ok      = ({1'b0, out_q} + {1'b0, cnt_q}) < 3'd2;
    assign imem_req_valid = rst & ~redirect_valid & credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // Responses to requests issued before a redirect are stale and discarded.
    assign rsp_drop = imem_rsp_valid & (drop_q != 2'd0);
    assign rsp_keep = imem_rsp_valid & (drop_q == 2'd0) & ~redirect_valid;

    // Live responses go straight to IF/ID when the buffer is empty and decode is free.
    assign pop  = ~id_stall & (cnt_q != 2'd0);
    assign push = rsp_keep & ~(~id_stall & (cnt_q == 2'd0));

    // Responses come back in order, so the tag is just the next expected fetch address.
    assign rsp_ent     = '{dat: imem_rsp_data, pc: rsp_pc_q};
    assign redir_pc_al = {redirect_pc[31:2], 2'b00};

    // Outstanding request count: +1 on acceptance, -1 on any returned response.
    always_comb begin
        out_d = out_q;
        if (req_fire && !imem_rsp_valid) begin
            out_d = out_q + 2'd1;
        end else if (!req_fire && imem_rsp_valid) begin
            out_d = out_q - 2'd1;
        end
    end

    // Next state for fetch PC, drop counter, response buffer and IF/ID register.
    always_comb begin
        pc_d         = pc_q;
        drop_d       = drop_q;
        cnt_d        = cnt_q;
        cnt_pop      = cnt_q;
        buf0_d       = buf0_q;
        buf1_d       = buf1_q;
        rsp_pc_d     = rsp_pc_q;
        ifid_dat_d   = ifid_dat_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_flush_d = ifid_flush_q;
        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path,
            // which already includes any earlier pending drops, so it stays <= 2.
            pc_d         = redir_pc_al;
            cnt_d        = 2'd0;
            drop_d       = out_d;
            rsp_pc_d     = redir_pc_al;
            ifid_dat_d   = NOP_INSTR;
            ifid_flush_d = 1'b1;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (rsp_drop) begin
                drop_d = drop_q - 2'd1;
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (!id_stall) begin
                if (cnt_q != 2'd0) begin
                    ifid_dat_d   = buf0_q.dat;
                    ifid_pc_d    = buf0_q.pc;
                    ifid_flush_d = 1'b0;
                end else if (rsp_keep) begin
                    ifid_dat_d   = rsp_ent.dat;
                    ifid_pc_d    = rsp_ent.pc;
                    ifid_flush_d = 1'b0;
                end else begin
                    ifid_dat_d   = NOP_INSTR;
                    ifid_flush_d = 1'b1;
                end
            end
            if (pop) begin
                buf0_d  = buf1_q;
                cnt_pop = cnt_q - 2'd1;
            end
            if (push) begin
                if (cnt_pop == 2'd0) begin
                    buf0_d = rsp_ent;
                end else begin
                    buf1_d = rsp_ent;
                end
                cnt_d = cnt_pop + 2'd1;
            end else begin
                cnt_d = cnt_pop;
            end
        end
    end

    // State registers with synchronous active-low reset; reset abandons all in-flight work.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q         <= {RESET_PC[31:2], 2'b00};
            out_q        <= 2'd0;
            drop_q       <= 2'd0;
            cnt_q        <= 2'd0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            rsp_pc_q     <= {RESET_PC[31:2], 2'b00};
            ifid_dat_q   <= NOP_INSTR;
            ifid_pc_q    <= RESET_PC;
            ifid_flush_q <= 1'b1;
        end else begin
            pc_q         <= pc_d;
            out_q        <= out_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            rsp_pc_q     <= rsp_pc_d;
            ifid_dat_q   <= ifid_dat_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_flush_q <= ifid_flush_d;
        end
    end

    assign instruction_out = ifid_dat_q;
    assign pc_out          = ifid_pc_q;
    assign id_flush        = ifid_flush_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: self-checking bench for fetch_unit with an in-order memory model and a queue-based reference.
// Latency: memory latency is a bench variable (1..3 cycles) changed per scenario.
// Backpressure: ready, id_stall and redirect are driven from directed scenarios and a fixed pattern table.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        id_flush;

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_stall        (id_stall),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .id_flush        (id_flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: each word is a simple function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'hA;
    endfunction

    // Requests accepted by memory, oldest first; stale marks a response the fetch unit must discard.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;
    typedef struct {
        logic [31:0] dat;
        logic [31:0] pc;
    } bent_t;

    mreq_t       mq[$];
    bent_t       mbuf[$];
    bit          m_init = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;
    logic        m_flush;

    // Compare process: checks registered outputs, drives memory responses, checks
    // the request outputs, then advances the reference to the upcoming edge.
    always @(negedge clk) begin : cmp
        mreq_t hd;
        bent_t be;
        bent_t hb;
        logic  rsp_now;
        logic  live;
        logic  acc;
        logic  mv;
        if (m_init) begin
            check("instruction_out", instruction_out, m_instr);
            check("pc_out", pc_out, m_pcout);
            check("id_flush", {31'd0, id_flush}, {31'd0, m_flush});
        end
        rsp_now        = rst && (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
        #1;
        mv = rst && !redirect_valid && ((mq.size() + mbuf.size()) < 2);
        if (m_init || !rst) check("imem_req_valid", {31'd0, imem_req_valid}, {31'd0, mv});
        if (m_init && rst) check("imem_req_addr", imem_req_addr, m_pc);
        acc = imem_req_valid && imem_req_ready;
        if (!rst) begin
            mq.delete();
            mbuf.delete();
            m_pc    = RST_PC;
            m_instr = NOP;
            m_pcout = RST_PC;
            m_flush = 1'b1;
            m_init  = 1'b1;
        end else if (m_init) begin
            live = 1'b0;
            be   = '{dat: 32'h0, pc: 32'h0};
            if (rsp_now) begin
                hd   = mq.pop_front();
                live = !hd.stale && !redirect_valid;
                be   = '{dat: mem_word(hd.addr), pc: hd.addr};
            end
            if (acc) mq.push_back('{addr: imem_req_addr, due: cyc + lat, stale: 1'b0});
            if (redirect_valid) begin
                m_pc = {redirect_pc[31:2], 2'b00};
                mbuf.delete();
                m_instr = NOP;
                m_flush = 1'b1;
                foreach (mq[i]) mq[i].stale = 1'b1;
            end else begin
                if (acc) m_pc = m_pc + 32'd4;
                if (!id_stall) begin
                    if (mbuf.size() > 0) begin
                        hb      = mbuf.pop_front();
                        m_instr = hb.dat;
                        m_pcout = hb.pc;
                        m_flush = 1'b0;
                        if (live) mbuf.push_back(be);
                    end else if (live) begin
                        m_instr = be.dat;
                        m_pcout = be.pc;
                        m_flush = 1'b0;
                    end else begin
                        m_instr = NOP;
                        m_flush = 1'b1;
                    end
                end else if (live) begin
                    mbuf.push_back(be);
                end
            end
            check("outstanding_le2", {31'd0, (mq.size() <= 2)}, 32'd1);
            check("buffer_le2", {31'd0, (mbuf.size() <= 2)}, 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_stall       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        lat            = 1;

        // Reset values, then straight-line fetch of 0xA, 0xB, 0xC.
        tick(); tick();
        check("rst_instr", instruction_out, NOP);
        check("rst_pc", pc_out, RST_PC);
        check("rst_flush", {31'd0, id_flush}, 32'd1);
        check("rst_valid", {31'd0, imem_req_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check("first_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_addr", imem_req_addr, 32'h0);
        tick(); tick();
        check("seq0_instr", instruction_out, 32'hA);
        check("seq0_pc", pc_out, 32'h0);
        check("seq0_flush", {31'd0, id_flush}, 32'd0);
        tick();
        check("seq1_instr", instruction_out, 32'hB);
        check("seq1_pc", pc_out, 32'h4);
        tick();
        check("seq2_instr", instruction_out, 32'hC);
        check("seq2_pc", pc_out, 32'h8);

        // Memory not ready for 3 cycles at 0x8.
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        imem_req_ready = 1'b0;
        tick();
        check("nrdy_valid", {31'd0, imem_req_valid}, 32'd1);
        check("nrdy_addr", imem_req_addr, 32'h8);
        tick();
        check("nrdy_instr", instruction_out, NOP);
        check("nrdy_flush", {31'd0, id_flush}, 32'd1);
        check("nrdy_pc", pc_out, 32'h4);
        tick();
        imem_req_ready = 1'b1;
        tick(); tick();
        check("resume_pc", pc_out, 32'h8);
        check("resume_instr", instruction_out, 32'hC);
        tick(); tick();
        check("prestall_pc", pc_out, 32'h10);

        // Decode stall for 4 cycles: outputs frozen, buffer fills to 2, then drains in order.
        id_stall = 1'b1;
        tick();
        check("stall_pc", pc_out, 32'h10);
        check("stall_instr", instruction_out, 32'hE);
        check("stall_flush", {31'd0, id_flush}, 32'd0);
        tick();
        check("stall_credit_valid", {31'd0, imem_req_valid}, 32'd0);
        check("stall_pc2", pc_out, 32'h10);
        tick(); tick();
        check("stall_pc4", pc_out, 32'h10);
        id_stall = 1'b0;
        tick();
        check("drain0_pc", pc_out, 32'h14);
        check("drain0_instr", instruction_out, 32'hF);
        tick();
        check("drain1_pc", pc_out, 32'h18);
        tick();
        check("drain2_pc", pc_out, 32'h1C);
        check("drain2_flush", {31'd0, id_flush}, 32'd0);
        tick();
        check("drain3_pc", pc_out, 32'h20);

        // Redirect to 0x100 with two requests outstanding (latency 3).
        rst = 1'b0;
        lat = 3;
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("redir_instr", instruction_out, NOP);
        check("redir_flush", {31'd0, id_flush}, 32'd1);
        tick();
        #1;
        check("redir_valid", {31'd0, imem_req_valid}, 32'd1);
        check("redir_addr", imem_req_addr, 32'h100);
        tick(); tick(); tick();
        check("redir_drop_flush", {31'd0, id_flush}, 32'd1);
        tick();
        check("redir_new_pc", pc_out, 32'h100);
        check("redir_new_instr", instruction_out, 32'h4A);
        check("redir_new_flush", {31'd0, id_flush}, 32'd0);

        // Redirect to unaligned 0x203 together with a stall and a live response.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        id_stall       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        id_stall       = 1'b0;
        check("redir2_flush", {31'd0, id_flush}, 32'd1);
        check("redir2_instr", instruction_out, NOP);
        #1;
        check("redir2_addr", imem_req_addr, 32'h200);
        check("redir2_valid", {31'd0, imem_req_valid}, 32'd1);
        for (int i = 0; i < 6; i++) tick();

        // Mixed pattern of ready, stall and redirect with latency 2.
        lat = 2;
        for (int i = 0; i < 48; i++) begin
            imem_req_ready = (i % 3) != 0;
            id_stall       = ((i % 5) == 2) || ((i % 7) == 3);
            redirect_valid = (i % 11) == 7;
            redirect_pc    = 32'h1000 + 32'(i) * 32'd8 + 32'd1;
            tick();
        end
        imem_req_ready = 1'b1;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // PC wrap, then reset pulsed mid-stream at 0x40.
        rst = 1'b0;
        lat = 1;
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        check("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (imem_req_addr == 32'h40) break;
            tick();
        end
        check("reach_0x40", imem_req_addr, 32'h40);
        rst = 1'b0;
        tick();
        check("midrst_instr", instruction_out, NOP);
        check("midrst_pc", pc_out, RST_PC);
        check("midrst_flush", {31'd0, id_flush}, 32'd1);
        check("midrst_valid", {31'd0, imem_req_valid}, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("restart_addr", imem_req_addr, RST_PC);
        check("restart_valid", {31'd0, imem_req_valid}, 32'd1);
        tick(); tick();
        check("restart_instr", instruction_out, 32'hA);
        check("restart_pc", pc_out, 32'h0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
